// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmit and receive sides:
// FSM state encodings, frame constants and the baud divisor helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  localparam int FRAME_DATA_BITS = 8;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last clock of
// each bit period with bit_end. restart forces the count back to zero.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic bit_end
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  assign bit_end = (cnt == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart || bit_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8 data bits LSB first, 1 or 2 stop bits, registered tx.
// Optional parity bit is built in when UART_TX_PARITY_EN is defined.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam logic [2:0] LAST_DATA = 3'(FRAME_DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 2 || STOP_BITS < 1 || STOP_BITS > 2 ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
    $error("uart_tx: unsupported CLK_FREQ/BAUD/STOP_BITS/PARITY_ODD combination");
  end

  uart_state_t state, state_next;
  logic [7:0]  shift, shift_next;
  logic [2:0]  bit_cnt, bit_cnt_next;
  logic        tx_next;
  logic        bit_end;
  logic        restart;
`ifdef UART_TX_PARITY_EN
  localparam logic PAR_SENSE = 1'(PARITY_ODD);
  logic        parity, parity_next;
`endif

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .rst_n  (rst_n),
    .restart(restart),
    .bit_end(bit_end)
  );

  assign ready = (state == IDLE);
  assign busy  = (state != IDLE);

  always_comb begin
    state_next   = state;
    shift_next   = shift;
    bit_cnt_next = bit_cnt;
    done         = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_next  = parity;
`endif
    case (state)
      IDLE: begin
        if (valid_in) begin
          state_next  = START;
          shift_next  = data_in;
`ifdef UART_TX_PARITY_EN
          parity_next = (^data_in) ^ PAR_SENSE;
`endif
        end
      end
      START: begin
        if (bit_end) state_next = DATA;
      end
      DATA: begin
        if (bit_end) begin
          shift_next = {1'b0, shift[7:1]};
          if (bit_cnt == LAST_DATA) begin
`ifdef UART_TX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end else begin
            bit_cnt_next = bit_cnt + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) state_next = STOP;
      end
`endif
      STOP: begin
        // bit_cnt counts stop bits here; done marks the final clock of the frame
        if (bit_end) begin
          if (bit_cnt == LAST_STOP) begin
            state_next = IDLE;
            done       = 1'b1;
          end else begin
            bit_cnt_next = bit_cnt + 3'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    if (state_next != state) bit_cnt_next = '0;
    restart = (state_next != state) || (state == IDLE);

    // tx is registered from the upcoming state so it changes with the state
    tx_next = 1'b1;
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_next = parity_next;
`endif
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      shift   <= '0;
      bit_cnt <= '0;
      tx      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity  <= 1'b0;
`endif
    end else begin
      state   <= state_next;
      shift   <= shift_next;
      bit_cnt <= bit_cnt_next;
      tx      <= tx_next;
`ifdef UART_TX_PARITY_EN
      parity  <= parity_next;
`endif
    end
  end

endmodule
